// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_hazard_ctrl_pkg: shared select codes, register width and EXE slot tag type
package fwd_hazard_ctrl_pkg;
    localparam int REG_AW = 5;
    localparam logic [1:0] SEL_VAL = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    typedef struct packed {
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic              two_src;
        logic [REG_AW-1:0] dest;
        logic              wb_en;
        logic              mem_read;
    } slot_t;
endpackage

// File: rtl/fwd_hazard_ctrl_match.sv
// fwd_match: a producer tag matches a source when it writes a nonzero register equal to that source
module fwd_match
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_dest,
    input  logic [AW-1:0] i_src,
    output logic          o_match
);
    assign o_match = i_wb_en && (i_dest != '0) && (i_dest == i_src);
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: shadows EXE/MEM/WB tags to drive EXE forwarding selects, the IF/ID
// hazard stall and a saturating stall-cycle counter
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_fwd_en,
    input  logic              i_freeze,
    input  logic              i_flush,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_src1,
    input  logic [REG_AW-1:0] i_id_src2,
    input  logic              i_id_two_src,
    input  logic [REG_AW-1:0] i_id_dest,
    input  logic              i_id_wb_en,
    input  logic              i_id_mem_read,
    output logic [1:0]        o_src1_sel,
    output logic [1:0]        o_src2_sel,
    output logic              o_hazard_stall,
    output logic [CNT_W-1:0]  o_stall_count
);
    slot_t             r_exe, w_id;
    logic [REG_AW-1:0] r_mem_dest, r_wb_dest;
    logic              r_mem_wb_en, r_mem_rd, r_wb_wb_en;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_m1, w_w1, w_m2, w_w2, w_e_id1, w_e_id2, w_m_id1, w_m_id2, w_raw;

    // forwarding comparators against the operands now in EXE
    fwd_match #(.AW(REG_AW)) u_m1 (.i_wb_en(r_mem_wb_en), .i_dest(r_mem_dest), .i_src(r_exe.src1), .o_match(w_m1));
    fwd_match #(.AW(REG_AW)) u_w1 (.i_wb_en(r_wb_wb_en), .i_dest(r_wb_dest), .i_src(r_exe.src1), .o_match(w_w1));
    fwd_match #(.AW(REG_AW)) u_m2 (.i_wb_en(r_mem_wb_en), .i_dest(r_mem_dest), .i_src(r_exe.src2), .o_match(w_m2));
    fwd_match #(.AW(REG_AW)) u_w2 (.i_wb_en(r_wb_wb_en), .i_dest(r_wb_dest), .i_src(r_exe.src2), .o_match(w_w2));
    // hazard comparators against the sources waiting in ID
    fwd_match #(.AW(REG_AW)) u_e_id1 (.i_wb_en(r_exe.wb_en), .i_dest(r_exe.dest), .i_src(i_id_src1), .o_match(w_e_id1));
    fwd_match #(.AW(REG_AW)) u_e_id2 (.i_wb_en(r_exe.wb_en), .i_dest(r_exe.dest), .i_src(i_id_src2), .o_match(w_e_id2));
    fwd_match #(.AW(REG_AW)) u_m_id1 (.i_wb_en(r_mem_wb_en), .i_dest(r_mem_dest), .i_src(i_id_src1), .o_match(w_m_id1));
    fwd_match #(.AW(REG_AW)) u_m_id2 (.i_wb_en(r_mem_wb_en), .i_dest(r_mem_dest), .i_src(i_id_src2), .o_match(w_m_id2));

    assign w_id = '{i_id_src1, i_id_src2, i_id_two_src, i_id_dest, i_id_wb_en, i_id_mem_read};

    // a load in MEM has no data yet, so it falls through to the WB check
    assign o_src1_sel = !i_fwd_en ? SEL_VAL :
                        (w_m1 && !r_mem_rd) ? SEL_MEM :
                        w_w1 ? SEL_WB : SEL_VAL;
    assign o_src2_sel = (!i_fwd_en || !r_exe.two_src) ? SEL_VAL :
                        (w_m2 && !r_mem_rd) ? SEL_MEM :
                        w_w2 ? SEL_WB : SEL_VAL;

    assign w_raw = i_fwd_en ? (r_exe.mem_read && (w_e_id1 || (i_id_two_src && w_e_id2)))
                            : (w_e_id1 || w_m_id1 || (i_id_two_src && (w_e_id2 || w_m_id2)));
    assign o_hazard_stall = i_id_valid && w_raw && !i_freeze && !i_flush;
    assign o_stall_count  = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exe       <= '0;
            r_mem_dest  <= '0;
            r_mem_wb_en <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_wb_dest   <= '0;
            r_wb_wb_en  <= 1'b0;
            r_cnt       <= '0;
        end else if (!i_freeze) begin
            r_wb_dest   <= r_mem_dest;
            r_wb_wb_en  <= r_mem_wb_en;
            r_mem_dest  <= r_exe.dest;
            r_mem_wb_en <= r_exe.wb_en;
            r_mem_rd    <= r_exe.mem_read;
            r_exe       <= (i_flush || o_hazard_stall || !i_id_valid) ? '0 : w_id;
            if (o_hazard_stall && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed checks of forwarding selects, stalls, flush/freeze and counter
module tb_fwd_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst, fwd_en, freeze, flush;
    logic       v, two, wb, mr;
    logic [4:0] s1, s2, d;
    logic [1:0] sel1, sel2;
    logic       stall;
    logic [3:0] cnt;
    int         n_cmp = 0;
    int         n_fail = 0;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .i_fwd_en(fwd_en), .i_freeze(freeze), .i_flush(flush),
        .i_id_valid(v), .i_id_src1(s1), .i_id_src2(s2), .i_id_two_src(two),
        .i_id_dest(d), .i_id_wb_en(wb), .i_id_mem_read(mr),
        .o_src1_sel(sel1), .o_src2_sel(sel2), .o_hazard_stall(stall), .o_stall_count(cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic iv, input logic [4:0] is1, input logic [4:0] is2,
                         input logic itwo, input logic [4:0] id, input logic iwb, input logic imr);
        v = iv; s1 = is1; s2 = is2; two = itwo; d = id; wb = iwb; mr = imr;
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sel(input string tag, input logic [1:0] e1, input logic [1:0] e2);
        chk({tag, "_sel1"}, {14'd0, sel1}, {14'd0, e1});
        chk({tag, "_sel2"}, {14'd0, sel2}, {14'd0, e2});
    endtask

    // one dependent pair with forwarding off: two stall cycles
    task automatic pair_nofwd();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd3, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        drain();
    endtask

    initial begin
        rst = 1'b1; fwd_en = 1'b1; freeze = 1'b0; flush = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_sel("reset", 2'b00, 2'b00);
        chk("reset_stall", {15'd0, stall}, 16'd0);
        chk("reset_cnt", {12'd0, cnt}, 16'd0);

        // add r3,r1,r2 ; sub r5,r3,r4
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);
        chk("exmem_nostall", {15'd0, stall}, 16'd0);
        tick();
        idle();
        chk_sel("exmem", 2'b01, 2'b00);
        drain();

        // r3 written in MEM and WB: MEM wins
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd3, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0); tick();
        idle();
        chk_sel("prio_mem", 2'b01, 2'b00);
        drain();

        // r3 only in WB, r9 in MEM
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd3, 5'd9, 1'b1, 5'd8, 1'b1, 1'b0); tick();
        idle();
        chk_sel("wb_only", 2'b10, 2'b01);
        drain();

        // r0 never forwards
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0); tick();
        idle();
        chk_sel("r0", 2'b00, 2'b00);
        drain();

        // src2 ignored when not a register operand
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd0, 5'd4, 1'b0, 5'd8, 1'b1, 1'b0); tick();
        idle();
        chk_sel("imm_src2", 2'b00, 2'b00);
        drain();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd0, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0); tick();
        idle();
        chk_sel("reg_src2", 2'b00, 2'b01);
        drain();

        // load-use: lw r2 ; add r6,r2,r2
        issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
        chk("lu_pre", {15'd0, stall}, 16'd0);
        tick();
        issue(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        chk("lu_stall", {15'd0, stall}, 16'd1);
        tick();
        chk("lu_after", {15'd0, stall}, 16'd0);
        chk_sel("lu_bubble", 2'b00, 2'b00);
        tick();
        idle();
        chk_sel("lu_wb", 2'b10, 2'b10);
        chk("lu_cnt", {12'd0, cnt}, 16'd1);
        drain();

        // forwarding disabled: add r3 ; use r3
        fwd_en = 1'b0;
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        chk("nf_pre", {15'd0, stall}, 16'd0);
        tick();
        issue(1'b1, 5'd3, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
        chk("nf_stall1", {15'd0, stall}, 16'd1);
        tick();
        chk("nf_stall2", {15'd0, stall}, 16'd1);
        tick();
        chk("nf_release", {15'd0, stall}, 16'd0);
        tick();
        idle();
        chk_sel("nf_sel", 2'b00, 2'b00);
        chk("nf_cnt", {12'd0, cnt}, 16'd3);
        drain();
        fwd_en = 1'b1;

        // flush during a load-use hazard
        issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_stall", {15'd0, stall}, 16'd0);
        tick();
        flush = 1'b0;
        idle();
        chk_sel("fl_bubble", 2'b00, 2'b00);
        chk("fl_cnt", {12'd0, cnt}, 16'd3);
        drain();

        // freeze for 3 cycles with a MEM forward in flight
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd5, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        freeze = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("frz_sel1", {14'd0, sel1}, 16'd1);
            tick();
        end
        fwd_en = 1'b0;
        #1;
        chk_sel("frz_nofwd", 2'b00, 2'b00);
        chk("frz_nostall", {15'd0, stall}, 16'd0);
        fwd_en = 1'b1;
        freeze = 1'b0;
        #1;
        chk("frz_sel_resume", {14'd0, sel1}, 16'd1);
        chk("frz_resume_stall", {15'd0, stall}, 16'd0);
        tick();
        idle();
        chk_sel("frz_next", 2'b01, 2'b00);
        chk("frz_cnt", {12'd0, cnt}, 16'd3);
        drain();

        // saturate the 4-bit counter: 3 + 6*2 = 15, then hold
        fwd_en = 1'b0;
        repeat (6) pair_nofwd();
        chk("sat_reach", {12'd0, cnt}, 16'd15);
        pair_nofwd();
        chk("sat_hold", {12'd0, cnt}, 16'd15);
        fwd_en = 1'b1;

        // reset mid-flight drops tags and clears the counter
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd3, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        chk_sel("pre_rst", 2'b01, 2'b01);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_sel("mid_rst", 2'b00, 2'b00);
        chk("mid_rst_cnt", {12'd0, cnt}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
